// File: rtl/a1_inv_serial.sv
// Nibble-serial, Boolean-shared inverse of the Midori64 A1 affine layer.
// One nibble of every share is transformed per cycle; shares never mix.
//
// state | meaning
// IDLE  | in_ready high, waiting for an input state
// RUN   | rotate-right by one nibble per cycle, transforming the low nibble
// DONE  | out_valid high, result held until out_ready
module a1_inv_serial #(
    parameter int SHARES = 3,
    parameter int N_NIB  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SHARES*4*N_NIB-1:0]   in_state,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SHARES*4*N_NIB-1:0]   out_state
);

    localparam int W  = 4 * N_NIB;
    localparam int CW = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic [SHARES*W-1:0]   sh;
    logic [SHARES*W-1:0]   sh_step;
    logic                  last;

    // The affine constant only lands on share 0 so the recombined value gets it once.
    function automatic logic [3:0] f_nib(input logic [3:0] o, input logic c);
        return {o[0] ^ o[3] ^ o[2] ^ o[1], o[3] ^ o[1] ^ c, o[3] ^ o[2], o[1]};
    endfunction

    for (genvar s = 0; s < SHARES; s++) begin : g_share
        assign sh_step[s*W +: W] = {f_nib(sh[s*W +: 4], (s == 0)), sh[s*W+4 +: W-4]};
    end

    assign last      = (cnt == CW'(N_NIB - 1));
    assign out_state = sh;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh  <= in_state;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sh  <= sh_step;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_a1_inv_serial.sv
// Directed and randomized bench for a1_inv_serial (3 shares, 16 nibbles).
module tb_a1_inv_serial;

    localparam int SH = 3;
    localparam int NN = 16;
    localparam int WW = 4 * NN;
    localparam int TW = SH * WW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_state;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    a1_inv_serial #(.SHARES(SH), .N_NIB(NN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TW-1:0] vin;
        logic [TW-1:0] vexp;
    } vec_t;

    vec_t tbl[3];

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hand-derived table of the linear part of A1^-1 (constant excluded).
    function automatic logic [3:0] lin(input logic [3:0] o);
        case (o)
            4'h0: return 4'h0;  4'h1: return 4'h8;  4'h2: return 4'hD;  4'h3: return 4'h5;
            4'h4: return 4'hA;  4'h5: return 4'h2;  4'h6: return 4'h7;  4'h7: return 4'hF;
            4'h8: return 4'hE;  4'h9: return 4'h6;  4'hA: return 4'h3;  4'hB: return 4'hB;
            4'hC: return 4'h4;  4'hD: return 4'hC;  4'hE: return 4'h9;  default: return 4'h1;
        endcase
    endfunction

    function automatic logic [TW-1:0] inv_model(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        logic [3:0]    n;
        r = '0;
        for (int s = 0; s < SH; s++)
            for (int k = 0; k < NN; k++) begin
                n = lin(v[s*WW + k*4 +: 4]);
                if (s == 0) n = n ^ 4'h4;
                r[s*WW + k*4 +: 4] = n;
            end
        return r;
    endfunction

    // Forward A1 on an unshared 64-bit value, used for the round-trip check.
    function automatic logic [WW-1:0] a1_fwd(input logic [WW-1:0] x);
        logic [WW-1:0] r;
        logic [3:0]    i, o;
        for (int k = 0; k < NN; k++) begin
            i    = x[k*4 +: 4];
            o[1] = i[0];
            o[3] = i[2] ^ i[0] ^ 1'b1;
            o[2] = i[1] ^ o[3];
            o[0] = i[3] ^ i[1] ^ i[0];
            r[k*4 +: 4] = o;
        end
        return r;
    endfunction

    function automatic logic [WW-1:0] xsh(input logic [TW-1:0] v);
        return v[0 +: WW] ^ v[WW +: WW] ^ v[2*WW +: WW];
    endfunction

    function automatic logic [TW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one state from IDLE, wait for DONE, return the result and latency, then release.
    task automatic transact(input logic [TW-1:0] v, output logic [TW-1:0] res, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        in_valid = 1'b1;
        in_state = v;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        if (!out_valid) chk("output_timeout", {{(TW-1){1'b0}}, out_valid}, {{(TW-1){1'b0}}, 1'b1});
        res = out_state;
        tick();
    endtask

    logic [TW-1:0] res, a, b, ra, rb, junk;
    int            lat, n;
    int            acc_cyc[5];
    logic [TW-1:0] b2b_in[5];
    logic [TW-1:0] b2b_out[$];

    initial begin
        tbl[0].vin  = '0;
        tbl[0].vexp = {64'h0, 64'h0, 64'h4444444444444444};
        tbl[1].vin  = {64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 64'hFFFFFFFFFFFFFFFF};
        tbl[1].vexp = {64'h3333333333333333, 64'h3333333333333333, 64'h5555555555555555};
        tbl[2].vin  = {64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
        tbl[2].vexp = {64'h19C4B36EF72A5D80, 64'h08D5A27FE63B4C91, 64'h4C91E63BA27F08D5};

        rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset_in_ready",  {{(TW-1){1'b0}}, in_ready},  {{(TW-1){1'b0}}, 1'b1});
        chk("reset_out_valid", {{(TW-1){1'b0}}, out_valid}, '0);
        chk("reset_out_state", out_state, '0);

        for (int t = 0; t < 3; t++) begin
            transact(tbl[t].vin, res, lat);
            chk($sformatf("vec%0d_result", t), res, tbl[t].vexp);
            chk($sformatf("vec%0d_latency", t), TW'(lat + 1), TW'(17));
        end
        transact(tbl[1].vin, res, lat);
        chk("masked_xor", TW'(xsh(res)), TW'(64'h5555555555555555));

        for (int t = 0; t < 1000; t++) begin
            a = rnd();
            transact(a, res, lat);
            chk("round_trip", TW'(a1_fwd(xsh(res))), TW'(xsh(a)));
        end

        a = rnd();
        b = a;
        b[2*WW +: WW] = b[2*WW +: WW] ^ 64'h0000_1000_0020_0001;
        transact(a, ra, lat);
        transact(b, rb, lat);
        chk("noncomp_share01", rb[0 +: 2*WW], ra[0 +: 2*WW]);
        chk("noncomp_share2_changed", TW'(ra[2*WW +: WW] != rb[2*WW +: WW]), TW'(1));

        // Backpressure with in_valid noise during RUN and DONE.
        a = tbl[2].vin;
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = a;
        tick();
        n = 0;
        while (!out_valid && n < 40) begin
            in_state = rnd();
            tick(); n++;
        end
        for (int k = 0; k < 10; k++) begin
            in_state = rnd();
            chk("bp_out_state", out_state, tbl[2].vexp);
            chk("bp_in_ready",  {{(TW-1){1'b0}}, in_ready},  '0);
            chk("bp_out_valid", {{(TW-1){1'b0}}, out_valid}, {{(TW-1){1'b0}}, 1'b1});
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", {{(TW-1){1'b0}}, in_ready}, {{(TW-1){1'b0}}, 1'b1});
        chk("bp_release_out_valid", {{(TW-1){1'b0}}, out_valid}, '0);

        // Reset while cnt = 7.
        in_valid = 1'b1; in_state = tbl[2].vin;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_in_ready",  {{(TW-1){1'b0}}, in_ready},  {{(TW-1){1'b0}}, 1'b1});
        chk("midrun_out_valid", {{(TW-1){1'b0}}, out_valid}, '0);
        chk("midrun_out_state", out_state, '0);
        transact(tbl[1].vin, res, lat);
        chk("after_reset_result", res, tbl[1].vexp);

        // Back-to-back: in_valid and out_ready held high.
        for (int k = 0; k < 5; k++) b2b_in[k] = rnd();
        in_valid = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            n = 0;
            while (!in_ready && n < 40) begin
                if (out_valid) b2b_out.push_back(out_state);
                tick(); n++;
            end
            if (k == 5) begin
                in_valid = 1'b0;
                break;
            end
            in_state = b2b_in[k];
            tick();
            acc_cyc[k] = cyc;
        end
        for (int k = 1; k < 5; k++)
            chk("b2b_interval", TW'(acc_cyc[k] - acc_cyc[k-1]), TW'(18));
        chk("b2b_count", TW'(b2b_out.size()), TW'(5));
        for (int k = 0; k < 5 && k < b2b_out.size(); k++)
            chk($sformatf("b2b_result%0d", k), b2b_out[k], inv_model(b2b_in[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/a1_inv_serial.md
# a1_inv_serial

Nibble-serial, threshold-shared inverse of the Midori64 A1 affine layer. It accepts a SHARES-way Boolean-shared 64-bit state through a valid/ready handshake. It applies the inverse affine map A1⁻¹ to one nibble of every share per cycle and presents the full result through a second valid/ready handshake. It sits on the decryption datapath, where it undoes the A1 stage of the decomposed S-box.

## Interface

Parameters:
- SHARES, 3: number of Boolean shares; must be ≥ 2.
- N_NIB, 16: nibbles per share. Each share is 4*N_NIB bits wide.

Ports (W = 4*N_NIB):
- clk  in  1  single clock; all logic updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  input state is valid.
- in_ready  out  1  block can accept an input state.
- in_state  in  SHARES*W  share s occupies bits [s*W +: W].
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- out_state  out  SHARES*W  result, using the same share packing as in_state.

## Operation

Per-nibble map, with input bits o[3:0] and output bits i[3:0]:
- i0 = o1
- i1 = o3 ^ o2
- i2 = o3 ^ o1 ^ c
- i3 = o0 ^ o3 ^ o2 ^ o1

The constant c = 1 applies to share 0 only. For shares 1..SHARES-1, c = 0, so only the linear part is applied. The XOR of all output shares therefore equals A1⁻¹ of the XOR of all input shares. No share ever mixes with another share (non-completeness holds trivially).

State machine:
- **IDLE**
  - in_ready = 1.
  - When in_valid is high: load every share register from in_state, set cnt = 0, go to RUN.
- **RUN**
  - Every cycle, each share register becomes {f_s(reg[3:0]), reg[W-1:4]}. That is, the low nibble is transformed and reinserted at the top, giving a rotate-right by 4.
  - cnt increments each cycle.
  - When cnt = N_NIB-1, go to DONE. After N_NIB steps every nibble has been transformed exactly once and is back in its original position.
- **DONE**
  - out_valid = 1.
  - out_state = share registers, held stable.
  - When out_ready is high, go to IDLE.

Other rules:
- cnt width is clog2(N_NIB). cnt does not wrap in use, because the exit happens at N_NIB-1.
- in_ready is low in RUN and DONE. in_valid is ignored there, and in_state changes have no effect.
- out_valid is low in IDLE and RUN. out_ready is ignored there.
- No bypass: a new state is accepted no earlier than the cycle after the output handshake.

## Timing

- Reset values: state = IDLE, cnt = 0, share registers = 0, in_ready = 1 (the cycle after rst is sampled high), out_valid = 0, out_state = 0.
- Reset mid-operation (RUN or DONE): the in-flight state is discarded and the block returns to the reset values on the next cycle.
- rst dominates in_valid and out_ready in the same cycle.
- Latency: an input handshake sampled at the end of cycle t gives out_valid = 1 in cycle t+1+N_NIB (t+17 for defaults).
- Throughput: one state per N_NIB+2 cycles with out_ready held high (IDLE accept, N_NIB RUN, DONE).
- Output hold: if out_ready is low in DONE, out_valid and out_state stay constant indefinitely.
- All outputs come directly from registers or the state decode. There is no combinational path from in_* to out_*.

## Test plan

1. **Zero state.** Reset, then send all shares = 0.
   - Expect out_valid exactly 17 cycles after the accept.
   - share0 = 0x4444444444444444, shares 1 and 2 = 0.
2. **Masked all-ones.** Send share0 = 0xFFFFFFFFFFFFFFFF, share1 = share2 = 0xAAAAAAAAAAAAAAAA.
   - Expect share0 = 0x5555555555555555, share1 = share2 = 0x3333333333333333.
   - XOR of the output shares = 0x5555555555555555.
3. **Round trip.** Send 1000 random shared states.
   - Apply the reference A1 nibble-wise to the XOR of the output shares.
   - The result must equal the XOR of the input shares.
   - Also check that each output share depends only on its own input share: flipping only share 2 changes only output share 2.
4. **Backpressure.** Hold out_ready = 0 for 10 cycles in DONE.
   - out_state is stable and in_ready = 0 throughout.
   - in_valid pulses with new data during RUN and DONE are ignored.
   - Releasing out_ready gives in_ready = 1 on the next cycle.
5. **Reset mid-RUN.** Assert rst at cnt = 7.
   - Next cycle: in_ready = 1, out_valid = 0, out_state = 0.
   - A following transaction with the vector from scenario 2 produces the correct result.
6. **Back-to-back.** Keep in_valid and out_ready high continuously for 5 states.
   - Accepts occur every 18 cycles and results appear in order.
